// File: rtl/bp_uce_mem_arbiter_pkg.sv
// Shared widths and the CCE memory message layout used by the UCE memory arbiter.
package bp_uce_mem_arbiter_pkg;

  localparam int paddr_width_p      = 40;
  localparam int cce_block_width_p  = 64;
  localparam int lce_id_width_p     = 4;
  localparam int uce_assoc_lp       = 4;
  localparam int way_id_width_lp    = $clog2(uce_assoc_lp);
  localparam int uce_max_credits_gp = 8;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } bp_cce_mem_cmd_type_e;

  typedef struct packed {
    logic [way_id_width_lp-1:0] way_id;
    logic [lce_id_width_p-1:0]  lce_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_cmd_type_e           msg_type;
    logic [2:0]                     size;
    logic [paddr_width_p-1:0]       addr;
    bp_cce_mem_payload_s            payload;
    logic [cce_block_width_p-1:0]   data;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

endpackage

// File: rtl/bp_uce_mem_arbiter_credit_counter.sv
// Up/down outstanding-command counter with full and empty flags.
module bp_uce_mem_arbiter_credit_counter #(
  parameter int max_credits_p  = 8,
  parameter int credit_width_p = $clog2(max_credits_p + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [credit_width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i)
      count_d = count_q + 1'b1;
    else if (dec_i && !inc_i)
      count_d = count_q - 1'b1;
    full_o  = (count_q == credit_width_p'(max_credits_p));
    empty_o = (count_q == '0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      count_q <= '0;
    else
      count_q <= count_d;
  end

`ifndef SYNTHESIS
  // A return with nothing outstanding means the response routing is broken.
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!(dec_i && empty_o));
  end
`endif

endmodule

// File: rtl/bp_uce_mem_arbiter.sv
// Two-to-one UCE memory command arbiter with per-requester credits and
// lce_id-based response steering.
module bp_uce_mem_arbiter
  import bp_uce_mem_arbiter_pkg::*;
#(
  parameter int  max_credits_p   = uce_max_credits_gp,
  localparam int credit_width_lp = $clog2(max_credits_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [1:0][lce_id_width_p-1:0]      lce_id_i,

  input  bp_cce_mem_msg_s [1:0]               mem_cmd_i,
  input  logic [1:0]                          mem_cmd_v_i,
  output logic [1:0]                          mem_cmd_ready_o,

  output bp_cce_mem_msg_s                     mem_cmd_o,
  output logic                                mem_cmd_v_o,
  input  logic                                mem_cmd_ready_i,

  input  bp_cce_mem_msg_s                     mem_resp_i,
  input  logic                                mem_resp_v_i,
  output logic                                mem_resp_yumi_o,

  output bp_cce_mem_msg_s                     mem_resp_o,
  output logic [1:0]                          mem_resp_v_o,
  input  logic [1:0]                          mem_resp_yumi_i,

  output logic [1:0]                          credits_full_o,
  output logic [1:0]                          credits_empty_o,
  output logic                                route_error_o
);

  bp_cce_mem_msg_s [1:0] buf_q, buf_d;
  logic [1:0] buf_v_q, buf_v_d;
  logic       pri_q, pri_d;
  logic       grant;
  logic [1:0] deq, acc, match_raw, match, dec;

  // Command side: one-entry buffers, round-robin pick, refill allowed on dequeue
  always_comb begin
    grant       = (&buf_v_q) ? pri_q : buf_v_q[1];
    mem_cmd_v_o = |buf_v_q;
    mem_cmd_o   = buf_q[grant];
    deq         = '0;
    deq[grant]  = mem_cmd_v_o & mem_cmd_ready_i;
    for (int k = 0; k < 2; k++) begin
      mem_cmd_ready_o[k] = (~buf_v_q[k] | deq[k]) & ~credits_full_o[k];
      acc[k]             = mem_cmd_v_i[k] & mem_cmd_ready_o[k];
      buf_v_d[k]         = acc[k] | (buf_v_q[k] & ~deq[k]);
      buf_d[k]           = acc[k] ? mem_cmd_i[k] : buf_q[k];
    end
    pri_d = (|deq) ? ~grant : pri_q;
  end

  // Response side is purely combinational; requester 0 wins an id collision
  always_comb begin
    for (int k = 0; k < 2; k++)
      match_raw[k] = (mem_resp_i.payload.lce_id == lce_id_i[k]);
    match           = {match_raw[1] & ~match_raw[0], match_raw[0]};
    mem_resp_o      = mem_resp_i;
    mem_resp_v_o    = {2{mem_resp_v_i}} & match;
    dec             = mem_resp_yumi_i & mem_resp_v_o;
    mem_resp_yumi_o = |dec;
    route_error_o   = mem_resp_v_i & ~|match_raw;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_v_q <= '0;
      pri_q   <= 1'b0;
    end else begin
      buf_v_q <= buf_v_d;
      pri_q   <= pri_d;
    end
  end

  // Payload is qualified by buf_v_q, so it carries no reset.
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  bp_uce_mem_arbiter_credit_counter #(
    .max_credits_p (max_credits_p),
    .credit_width_p(credit_width_lp)
  ) u_cnt0 (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .inc_i  (acc[0]),
    .dec_i  (dec[0]),
    .full_o (credits_full_o[0]),
    .empty_o(credits_empty_o[0])
  );

  bp_uce_mem_arbiter_credit_counter #(
    .max_credits_p (max_credits_p),
    .credit_width_p(credit_width_lp)
  ) u_cnt1 (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .inc_i  (acc[1]),
    .dec_i  (dec[1]),
    .full_o (credits_full_o[1]),
    .empty_o(credits_empty_o[1])
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!(|(mem_resp_yumi_i & ~mem_resp_v_o)));
  end
`endif

endmodule
